led_pattern_seq: RTL and testbench

Pattern sequencer sitting directly downstream of the divided-clock generator: it samples the divided square wave in the system clock domain and advances an LED pattern by one step per rising edge. It converts the slow, asynchronous-to-logic divided clock into single-cycle advance events and drives the board LEDs. Supported patterns: rotate-left, rotate-right, bounce and blink. Mode changes take effect immediately.

---
 rtl/led_pattern_seq.sv | 173 +++++++++++++++++
 tb/tb_led_pattern_seq.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_seq.sv
// LED pattern sequencer: samples the divided tick_clk and steps rotate/bounce/blink patterns.
// Optional BOUNCE mode is enabled by LED_SEQ_BOUNCE_EN; without it, mode 2 aliases SHIFT_L.

module led_pattern_seq #(
    parameter int WIDTH       = 10,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_clk,
    input  logic [1:0]       mode,
    input  logic             run,
    output logic [WIDTH-1:0] leds,
    output logic             step,
    output logic [15:0]      wraps
);

    typedef enum logic [1:0] {
        SHIFT_L = 2'd0,
        SHIFT_R = 2'd1,
        BOUNCE  = 2'd2,
        BLINK   = 2'd3
    } mode_t;

`ifdef LED_SEQ_BOUNCE_EN
    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;
`endif

    localparam logic [WIDTH-1:0] SEED_LO = WIDTH'(1);
    localparam logic [WIDTH-1:0] SEED_HI = SEED_LO << (WIDTH - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [SYNC_STAGES-1:0] r_vld;
    logic                   r_prev;
    logic                   r_armed;
    logic                   r_adv;
    logic                   w_tick_s;
    logic                   w_adv;

    mode_t                  r_cur_mode;
    logic [WIDTH-1:0]       r_leds;
    logic                   r_step;
    logic [15:0]            r_wraps;

    mode_t                  w_mode_in;
    mode_t                  w_mode_nxt;
    logic [WIDTH-1:0]       w_leds_nxt;
    logic                   w_step_nxt;
    logic [15:0]            w_wraps_nxt;

`ifdef LED_SEQ_BOUNCE_EN
    dir_t                   r_dir;
    dir_t                   w_dir_nxt;
`endif

    function automatic logic [WIDTH-1:0] seed_of(input mode_t m);
        case (m)
            SHIFT_R: seed_of = SEED_HI;
            BLINK:   seed_of = '1;
            default: seed_of = SEED_LO;
        endcase
    endfunction

    assign w_tick_s  = r_sync[SYNC_STAGES-1];
    assign w_mode_in = mode_t'(mode);

    // r_armed blocks edges until a real low has crossed the synchronizer, so a
    // tick_clk held high through reset is not mistaken for a rising edge.
    assign w_adv = w_tick_s & ~r_prev & r_armed;

    // NOTE: every clocked assignment is non-blocking so all flops sample pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync  <= '0;
            r_vld   <= '0;
            r_prev  <= 1'b0;
            r_armed <= 1'b0;
            r_adv   <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], tick_clk};
            r_vld   <= {r_vld[SYNC_STAGES-2:0], 1'b1};
            r_prev  <= w_tick_s;
            if (r_vld[SYNC_STAGES-1] && !w_tick_s)
                r_armed <= 1'b1;
            r_adv   <= w_adv;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cur_mode <= SHIFT_L;
            r_leds     <= SEED_LO;
            r_step     <= 1'b0;
            r_wraps    <= '0;
`ifdef LED_SEQ_BOUNCE_EN
            r_dir      <= DIR_UP;
`endif
        end else begin
            r_cur_mode <= w_mode_nxt;
            r_leds     <= w_leds_nxt;
            r_step     <= w_step_nxt;
            r_wraps    <= w_wraps_nxt;
`ifdef LED_SEQ_BOUNCE_EN
            r_dir      <= w_dir_nxt;
`endif
        end
    end

    // Next-state logic; a mode change outranks any pending advance.
    // NOTE: each target gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        w_mode_nxt  = r_cur_mode;
        w_leds_nxt  = r_leds;
        w_step_nxt  = 1'b0;
        w_wraps_nxt = r_wraps;
`ifdef LED_SEQ_BOUNCE_EN
        w_dir_nxt   = r_dir;
`endif
        if (w_mode_in != r_cur_mode) begin
            w_mode_nxt = w_mode_in;
            w_leds_nxt = seed_of(w_mode_in);
`ifdef LED_SEQ_BOUNCE_EN
            w_dir_nxt  = DIR_UP;
`endif
        end else if (r_adv && run) begin
            w_step_nxt = 1'b1;
            case (r_cur_mode)
                SHIFT_R: begin
                    w_leds_nxt = {r_leds[0], r_leds[WIDTH-1:1]};
                    if (r_leds[0])
                        w_wraps_nxt = r_wraps + 16'd1;
                end
`ifdef LED_SEQ_BOUNCE_EN
                BOUNCE: begin
                    if (r_dir == DIR_UP) begin
                        w_leds_nxt = r_leds << 1;
                        if (r_leds[WIDTH-2])
                            w_dir_nxt = DIR_DOWN;
                    end else begin
                        w_leds_nxt = r_leds >> 1;
                        if (r_leds[1]) begin
                            w_dir_nxt   = DIR_UP;
                            w_wraps_nxt = r_wraps + 16'd1;
                        end
                    end
                end
`endif
                BLINK: begin
                    w_leds_nxt = ~r_leds;
                    if (r_leds == '0)
                        w_wraps_nxt = r_wraps + 16'd1;
                end
                default: begin
                    w_leds_nxt = {r_leds[WIDTH-2:0], r_leds[WIDTH-1]};
                    if (r_leds[WIDTH-1])
                        w_wraps_nxt = r_wraps + 16'd1;
                end
            endcase
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        leds  = r_leds;
        step  = r_step;
        wraps = r_wraps;
    end

endmodule

// File: tb/tb_led_pattern_seq.sv
// Self-checking bench for led_pattern_seq: position/phase model compared every cycle,
// plus directed literal expectations. Honours LED_SEQ_BOUNCE_EN like the design.

module tb_led_pattern_seq;

    localparam int W    = 10;
    localparam int SYNC = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         tick_clk;
    logic [1:0]   mode;
    logic         run;
    logic [W-1:0] leds;
    logic         step;
    logic [15:0]  wraps;

    int checks   = 0;
    int errors   = 0;
    int step_cnt = 0;

    always #5 clk = ~clk;

    led_pattern_seq #(.WIDTH(W), .SYNC_STAGES(SYNC)) dut (
        .clk      (clk),
        .rst      (rst),
        .tick_clk (tick_clk),
        .mode     (mode),
        .run      (run),
        .leds     (leds),
        .step     (step),
        .wraps    (wraps)
    );

    // Model: shift modes track a lit position, bounce a phase 0..2W-3, blink an on flag.
    // Tick edges are found from the raw tick_clk history sampled at each clk edge.
    typedef struct {
        logic [1:0]  mode;
        int          pos;
        int          ph;
        bit          on;
        logic [15:0] wraps;
        bit          step;
        logic [63:0] hist;
        int          seen;
    } model_t;

    model_t m;

    function automatic int eff_mode(input logic [1:0] md);
`ifdef LED_SEQ_BOUNCE_EN
        return int'(md);
`else
        return (md == 2'd2) ? 0 : int'(md);
`endif
    endfunction

    function automatic model_t model_reset();
        model_t r;
        r.mode  = 2'd0;
        r.pos   = 0;
        r.ph    = 0;
        r.on    = 1'b1;
        r.wraps = '0;
        r.step  = 1'b0;
        r.hist  = '0;
        r.seen  = 0;
        return r;
    endfunction

    function automatic model_t model_next(input model_t s, input logic [1:0] md,
                                          input logic rn, input logic tk);
        model_t r;
        bit     ev;
        r      = s;
        r.step = 1'b0;
        // Rising tick sampled SYNC+1 edges ago, with a low sampled just before it.
        ev = (s.seen >= SYNC + 2) && s.hist[SYNC] && !s.hist[SYNC+1];
        if (md != s.mode) begin
            r.mode = md;
            r.pos  = (md == 2'd1) ? W - 1 : 0;
            r.ph   = 0;
            r.on   = 1'b1;
        end else if (ev && rn) begin
            r.step = 1'b1;
            case (eff_mode(s.mode))
                1: begin
                    r.pos = (s.pos + W - 1) % W;
                    if (r.pos == W - 1) r.wraps = s.wraps + 16'd1;
                end
                2: begin
                    r.ph = (s.ph + 1) % (2 * W - 2);
                    if (r.ph == 0) r.wraps = s.wraps + 16'd1;
                end
                3: begin
                    r.on = !s.on;
                    if (r.on) r.wraps = s.wraps + 16'd1;
                end
                default: begin
                    r.pos = (s.pos + 1) % W;
                    if (r.pos == 0) r.wraps = s.wraps + 16'd1;
                end
            endcase
        end
        r.hist = {s.hist[62:0], tk};
        if (s.seen < 1000) r.seen = s.seen + 1;
        return r;
    endfunction

    function automatic logic [W-1:0] exp_leds(input model_t s);
        logic [W-1:0] one;
        one = W'(1);
        case (eff_mode(s.mode))
            2:       return (s.ph < W) ? (one << s.ph) : (one << (2 * W - 2 - s.ph));
            3:       return s.on ? '1 : '0;
            default: return one << s.pos;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) m <= model_reset();
        else     m <= model_next(m, mode, run, tick_clk);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            check("model_leds",  32'(leds),  32'(exp_leds(m)));
            check("model_step",  32'(step),  32'(m.step));
            check("model_wraps", 32'(wraps), 32'(m.wraps));
            if (step) step_cnt++;
        end
    end

    task automatic do_reset(input logic [1:0] md);
        rst      = 1'b1;
        mode     = md;
        run      = 1'b1;
        tick_clk = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse();
        tick_clk = 1'b1;
        repeat (3) @(negedge clk);
        tick_clk = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) pulse();
    endtask

    initial begin
        int base;
        int lat;

        // Reset values
        rst      = 1'b1;
        mode     = 2'd0;
        run      = 1'b1;
        tick_clk = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_leds",  32'(leds),  32'h001);
        check("rst_step",  32'(step),  32'h0);
        check("rst_wraps", 32'(wraps), 32'h0);

        // SHIFT_L: ten ticks walk the lit bit around once
        do_reset(2'd0);
        check("shl_start", 32'(leds), 32'h001);
        base = step_cnt;
        for (int i = 1; i <= 10; i++) begin
            logic [W-1:0] one;
            one = W'(1);
            pulse();
            check("shl_seq", 32'(leds), 32'(one << (i % 10)));
        end
        check("shl_wraps", 32'(wraps), 32'd1);
        check("shl_steps", 32'(step_cnt - base), 32'd10);

        // Latency from tick rising edge to step
        lat = 99;
        tick_clk = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (step) begin
                lat = i;
                break;
            end
        end
        check("latency", 32'(lat), 32'(SYNC + 1));
        @(negedge clk);
        tick_clk = 1'b0;
        repeat (3) @(negedge clk);
        check("shl_after_lat", 32'(leds), 32'h002);

        // SHIFT_R held through reset: reload on first edge, no step
        rst      = 1'b1;
        mode     = 2'd1;
        tick_clk = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("shr_seed", 32'(leds), 32'h200);
        check("shr_seed_step", 32'(step), 32'h0);
        @(negedge clk);
        pulse();
        check("shr_1", 32'(leds), 32'h100);
        pulse();
        check("shr_2", 32'(leds), 32'h080);
        pulse();
        check("shr_3", 32'(leds), 32'h040);

        // Mode 2
        do_reset(2'd2);
        ticks(9);
        check("bnc_9", 32'(leds), 32'h200);
        ticks(9);
`ifdef LED_SEQ_BOUNCE_EN
        check("bnc_18", 32'(leds), 32'h001);
`else
        check("bnc_18", 32'(leds), 32'h100);
`endif
        check("bnc_wraps", 32'(wraps), 32'd1);

        // BLINK
        do_reset(2'd3);
        check("blk_seed", 32'(leds), 32'h3FF);
        pulse();
        check("blk_1", 32'(leds), 32'h000);
        pulse();
        check("blk_2", 32'(leds), 32'h3FF);
        pulse();
        check("blk_3", 32'(leds), 32'h000);
        pulse();
        check("blk_4", 32'(leds), 32'h3FF);
        check("blk_wraps", 32'(wraps), 32'd2);

        // run = 0 holds; mode change still reloads
        do_reset(2'd0);
        ticks(2);
        check("run_pre", 32'(leds), 32'h004);
        run  = 1'b0;
        base = step_cnt;
        ticks(5);
        check("run0_hold", 32'(leds), 32'h004);
        check("run0_steps", 32'(step_cnt - base), 32'd0);
        mode = 2'd1;
        repeat (2) @(negedge clk);
        check("run0_reload", 32'(leds), 32'h200);
        run  = 1'b1;
        pulse();
        check("run1_adv", 32'(leds), 32'h100);
        check("run1_steps", 32'(step_cnt - base), 32'd1);

        // Mode change coinciding with the advance: reload wins, no step
        do_reset(2'd0);
        pulse();
        check("coll_pre", 32'(leds), 32'h002);
        base = step_cnt;
        tick_clk = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        mode = 2'd1;
        @(posedge clk);
        #1;
        check("coll_leds", 32'(leds), 32'h200);
        check("coll_step", 32'(step), 32'h0);
        @(negedge clk);
        tick_clk = 1'b0;
        repeat (4) @(negedge clk);
        check("coll_steps", 32'(step_cnt - base), 32'd0);

        // Async reset mid-pattern with tick_clk high
        do_reset(2'd0);
        ticks(12);
        check("mid_leds", 32'(leds), 32'h004);
        check("mid_wraps", 32'(wraps), 32'd1);
        tick_clk = 1'b1;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_leds",  32'(leds),  32'h001);
        check("arst_wraps", 32'(wraps), 32'h0);
        check("arst_step",  32'(step),  32'h0);
        repeat (2) @(negedge clk);
        rst  = 1'b0;
        base = step_cnt;
        repeat (10) @(negedge clk);
        check("arst_nospur", 32'(step_cnt - base), 32'd0);
        check("arst_hold", 32'(leds), 32'h001);
        tick_clk = 1'b0;
        repeat (3) @(negedge clk);
        pulse();
        check("arst_next", 32'(leds), 32'h002);
        check("arst_steps", 32'(step_cnt - base), 32'd1);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
